comp_storage_pipe: RTL and testbench



---
 rtl/comp_storage_pkg.sv | 45 ++++
 rtl/cs_alu.sv | 51 +++++
 rtl/comp_storage_pipe.sv | 141 ++++++++++++++
 tb/tb_comp_storage_pipe.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_storage_pkg.sv
// Shared types and opcode helpers for the computational storage pipeline.
package comp_storage_pkg;

    typedef enum logic [2:0] {
        OP_READ  = 3'd0,
        OP_WRITE = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_AND   = 3'd4,
        OP_OR    = 3'd5,
        OP_XOR   = 3'd6,
        OP_COPY  = 3'd7
    } cs_op_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
    } cs_flags_t;

    // Control half of the stage-1 register; data fields are sized by the top's parameters.
    typedef struct packed {
        logic   valid;
        cs_op_e op;
        logic   sat;
        logic   bad;
    } cs_s1_t;

    function automatic logic uses_a(input cs_op_e op);
        return op != OP_WRITE;
    endfunction

    function automatic logic uses_b(input cs_op_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    endfunction

    function automatic logic uses_c(input cs_op_e op);
        return op != OP_READ;
    endfunction

    function automatic logic updates_flags(input cs_op_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    endfunction

endpackage

// File: rtl/cs_alu.sv
// Combinational execute unit: modulo or saturating add/sub, bitwise ops, pass-through.
module cs_alu
    import comp_storage_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [2:0]        op,
    input  logic              sat,
    output logic [DATA_W-1:0] result,
    output cs_flags_t         flags
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] raw;

    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        raw    = op_a;
        result = op_a;
        flags  = '0;
        case (cs_op_e'(op))
            OP_ADD: begin
                raw         = sum[MSB:0];
                flags.carry = sum[DATA_W];
                flags.ovf   = (op_a[MSB] == op_b[MSB]) && (raw[MSB] != op_a[MSB]);
                result      = (sat && sum[DATA_W]) ? '1 : raw;
            end
            OP_SUB: begin
                // The extra top bit of the widened difference is the unsigned borrow.
                raw         = diff[MSB:0];
                flags.carry = diff[DATA_W];
                flags.ovf   = (op_a[MSB] != op_b[MSB]) && (raw[MSB] != op_a[MSB]);
                result      = (sat && diff[DATA_W]) ? '0 : raw;
            end
            OP_AND:  result = op_a & op_b;
            OP_OR:   result = op_a | op_b;
            OP_XOR:  result = op_a ^ op_b;
            default: result = op_a;
        endcase
        flags.zero = (result == '0);
    end

endmodule

// File: rtl/comp_storage_pipe.sv
// Two-stage computational storage block: operand fetch with write forwarding,
// then execute/writeback, with a backpressured read response channel.
module comp_storage_pipe
    import comp_storage_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd,
    input  logic [ADDR_W-1:0] addA,
    input  logic [ADDR_W-1:0] addB,
    input  logic [ADDR_W-1:0] addC,
    input  logic [DATA_W-1:0] wdata,
    input  logic              sat_mode,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic              flag_ovf,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < DEPTH_L;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    cs_s1_t            s1_q;
    logic [ADDR_W-1:0] s1_addr_c;
    logic [DATA_W-1:0] s1_wdata;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    cs_flags_t         flags_q;

    logic              stall;
    logic              accept;
    logic              exec;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] alu_result;
    cs_flags_t         alu_flags;
    cs_op_e            cmd_op;
    logic              cmd_bad;
    logic [DATA_W-1:0] fetch_a;
    logic [DATA_W-1:0] fetch_b;

    assign stall     = rd_valid && !rd_ready;
    assign cmd_ready = !reset && !stall;
    assign accept    = cmd_valid && cmd_ready;
    assign exec      = s1_q.valid && !stall && !reset;

    assign cmd_op  = cs_op_e'(cmd);
    assign cmd_bad = (uses_a(cmd_op) && !in_range(addA))
                  || (uses_b(cmd_op) && !in_range(addB))
                  || (uses_c(cmd_op) && !in_range(addC));

    cs_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .op_a  (op_a_q),
        .op_b  (op_b_q),
        .op    (s1_q.op),
        .sat   (s1_q.sat),
        .result(alu_result),
        .flags (alu_flags)
    );

    assign wr_en   = exec && !s1_q.bad && (s1_q.op != OP_READ);
    assign wr_data = (s1_q.op == OP_WRITE) ? s1_wdata : alu_result;

    // A writeback landing on the same edge as this fetch must win over the stale word.
    always_comb begin
        fetch_a = '0;
        fetch_b = '0;
        if (in_range(addA)) begin
            fetch_a = (wr_en && (addA == s1_addr_c)) ? wr_data : mem[addA];
        end
        if (in_range(addB)) begin
            fetch_b = (wr_en && (addB == s1_addr_c)) ? wr_data : mem[addB];
        end
    end

    // NOTE: the storage array has no reset; clearing it would need a per-word sequencer and its contents must survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[s1_addr_c] <= wr_data;
        end
    end

    // Stage-1 data payload only matters while s1_q.valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_addr_c <= addC;
            s1_wdata  <= wdata;
            op_a_q    <= fetch_a;
            op_b_q    <= fetch_b;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= '0;
            rd_valid <= 1'b0;
            rdata    <= '0;
            flags_q  <= '0;
            err      <= 1'b0;
        end else if (stall) begin
            err <= 1'b0;
        end else begin
            s1_q.valid <= accept;
            if (accept) begin
                s1_q.op  <= cmd_op;
                s1_q.sat <= sat_mode;
                s1_q.bad <= cmd_bad;
            end
            err      <= exec && s1_q.bad;
            rd_valid <= exec && (s1_q.op == OP_READ);
            if (exec && (s1_q.op == OP_READ)) begin
                rdata <= s1_q.bad ? '0 : op_a_q;
            end
            if (exec && !s1_q.bad && updates_flags(s1_q.op)) begin
                flags_q <= alu_flags;
            end
        end
    end

    assign flag_zero  = flags_q.zero;
    assign flag_carry = flags_q.carry;
    assign flag_ovf   = flags_q.ovf;

endmodule

// File: tb/tb_comp_storage_pipe.sv
// Self-checking bench for comp_storage_pipe: directed scenarios plus a randomized
// run compared against a command-level reference model.
module tb_comp_storage_pipe;

    localparam int DW    = 16;
    localparam int DEPTH = 200;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd = '0;
    logic [AW-1:0] addA = '0;
    logic [AW-1:0] addB = '0;
    logic [AW-1:0] addC = '0;
    logic [DW-1:0] wdata = '0;
    logic          sat_mode = 1'b0;
    logic          rd_valid;
    logic          rd_ready = 1'b1;
    logic [DW-1:0] rdata;
    logic          flag_zero;
    logic          flag_carry;
    logic          flag_ovf;
    logic          err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    comp_storage_pipe #(
        .DATA_W(DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .addA      (addA),
        .addB      (addB),
        .addC      (addC),
        .wdata     (wdata),
        .sat_mode  (sat_mode),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rdata     (rdata),
        .flag_zero (flag_zero),
        .flag_carry(flag_carry),
        .flag_ovf  (flag_ovf),
        .err       (err)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          v;
        logic [2:0]    op;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [AW-1:0] c;
        logic [DW-1:0] wd;
        logic          sat;
    } mcmd_t;

    logic [DW-1:0] mem_m [DEPTH];
    mcmd_t         pend = '0;
    logic          e_rd_valid = 1'b0;
    logic [DW-1:0] e_rdata = '0;
    logic          e_zero = 1'b0;
    logic          e_carry = 1'b0;
    logic          e_ovf = 1'b0;
    logic          e_err = 1'b0;

    function automatic logic in_rng(input logic [AW-1:0] x);
        return int'(x) < DEPTH;
    endfunction

    // Applies one command to the model exactly as the opcode table describes it.
    task automatic model_exec(input mcmd_t m);
        int            ua, ub, sa, sb, r, rs;
        logic [DW-1:0] va, vb, st;
        logic          bad;
        bad = 1'b0;
        if (m.op != 3'd1 && !in_rng(m.a)) bad = 1'b1;
        if (m.op >= 3'd2 && m.op <= 3'd6 && !in_rng(m.b)) bad = 1'b1;
        if (m.op != 3'd0 && !in_rng(m.c)) bad = 1'b1;
        va = in_rng(m.a) ? mem_m[m.a] : '0;
        vb = in_rng(m.b) ? mem_m[m.b] : '0;
        ua = int'(va);
        ub = int'(vb);
        sa = $signed(va);
        sb = $signed(vb);
        e_err      = bad;
        e_rd_valid = (m.op == 3'd0);
        st         = va;
        if (m.op == 3'd0) begin
            e_rdata = bad ? '0 : va;
        end else if (!bad) begin
            case (m.op)
                3'd1: st = m.wd;
                3'd2: begin
                    r       = ua + ub;
                    rs      = sa + sb;
                    e_carry = (r > 65535);
                    e_ovf   = (rs > 32767) || (rs < -32768);
                    st      = (m.sat && e_carry) ? 16'hFFFF : r[15:0];
                    e_zero  = (st == 0);
                end
                3'd3: begin
                    r       = ua - ub;
                    rs      = sa - sb;
                    e_carry = (ua < ub);
                    e_ovf   = (rs > 32767) || (rs < -32768);
                    st      = (m.sat && e_carry) ? 16'h0000 : r[15:0];
                    e_zero  = (st == 0);
                end
                3'd4, 3'd5, 3'd6: begin
                    st      = (m.op == 3'd4) ? (va & vb) : (m.op == 3'd5) ? (va | vb) : (va ^ vb);
                    e_zero  = (st == 0);
                    e_carry = 1'b0;
                    e_ovf   = 1'b0;
                end
                default: st = va;
            endcase
            mem_m[m.c] = st;
        end
    endtask

    // One clock: drive at negedge, advance the model at posedge, settle #1 for sampling.
    task automatic step(input logic rst, input logic v, input logic [2:0] op,
                        input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c,
                        input logic [DW-1:0] wd, input logic sat, input logic rdy);
        logic  acc;
        mcmd_t nc;
        @(negedge clk);
        reset = rst; cmd_valid = v; cmd = op; addA = a; addB = b; addC = c;
        wdata = wd; sat_mode = sat; rd_ready = rdy;
        acc = !rst && v && !(e_rd_valid && !rdy);
        nc.v = acc; nc.op = op; nc.a = a; nc.b = b; nc.c = c; nc.wd = wd; nc.sat = sat;
        @(posedge clk);
        if (rst) begin
            e_rd_valid = 1'b0; e_rdata = '0; e_zero = 1'b0; e_carry = 1'b0; e_ovf = 1'b0;
            e_err = 1'b0; pend = '0;
        end else if (e_rd_valid && !rdy) begin
            e_err = 1'b0;
        end else begin
            if (pend.v) model_exec(pend);
            else begin
                e_rd_valid = 1'b0;
                e_err      = 1'b0;
            end
            pend = nc;
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 3'd0, '0, '0, '0, '0, 1'b0, rdy);
    endtask

    task automatic wr(input logic [AW-1:0] c, input logic [DW-1:0] d);
        step(1'b0, 1'b1, 3'd1, '0, '0, c, d, 1'b0, 1'b1);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b0, 1'b1, 3'd0, a, '0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic alu(input logic [2:0] op, input logic [AW-1:0] c, input logic [AW-1:0] a,
                       input logic [AW-1:0] b, input logic sat);
        step(1'b0, 1'b1, op, a, b, c, '0, sat, 1'b1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        step(1'b1, 1'b0, 3'd0, '0, '0, '0, '0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 3'd1, '0, '0, 8'd3, 16'h1111, 1'b0, 1'b1);
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
        checks++; if ({flag_zero, flag_carry, flag_ovf} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {flag_zero, flag_carry, flag_ovf}); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
        idle(1'b1);
    endtask

    task automatic fill_memory();
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), DW'($urandom));
        idle(1'b1);
    endtask

    task automatic test_forward();
        wr(8'd5, 16'h1234);
        rd(8'd5);
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL fwd_early_valid got=%b exp=0", rd_valid); end
        idle(1'b1);
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL fwd_valid got=%b exp=1", rd_valid); end
        checks++; if (rdata !== 16'h1234) begin failures++; $display("FAIL fwd_rdata got=%h exp=1234", rdata); end
    endtask

    task automatic test_add_carry();
        wr(8'd10, 16'hFFFF);
        wr(8'd11, 16'h0001);
        alu(3'd2, 8'd12, 8'd10, 8'd11, 1'b0);
        rd(8'd12);
        checks++; if ({flag_zero, flag_carry, flag_ovf} !== 3'b110) begin failures++; $display("FAIL add_flags got=%b exp=110", {flag_zero, flag_carry, flag_ovf}); end
        idle(1'b1);
        checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL add_result got=%h exp=0000", rdata); end
        alu(3'd2, 8'd12, 8'd10, 8'd11, 1'b1);
        rd(8'd12);
        checks++; if (flag_carry !== 1'b1) begin failures++; $display("FAIL add_sat_carry got=%b exp=1", flag_carry); end
        idle(1'b1);
        checks++; if (rdata !== 16'hFFFF) begin failures++; $display("FAIL add_sat_result got=%h exp=ffff", rdata); end
    endtask

    task automatic test_sub();
        wr(8'd1, 16'd3);
        wr(8'd2, 16'd5);
        alu(3'd3, 8'd3, 8'd1, 8'd2, 1'b0);
        rd(8'd3);
        checks++; if ({flag_carry, flag_ovf} !== 2'b10) begin failures++; $display("FAIL sub_flags got=%b exp=10", {flag_carry, flag_ovf}); end
        idle(1'b1);
        checks++; if (rdata !== 16'hFFFE) begin failures++; $display("FAIL sub_result got=%h exp=fffe", rdata); end
        alu(3'd3, 8'd3, 8'd1, 8'd2, 1'b1);
        rd(8'd3);
        idle(1'b1);
        checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL sub_sat_result got=%h exp=0000", rdata); end
    endtask

    task automatic test_ovf_logic();
        wr(8'd1, 16'h7FFF);
        wr(8'd2, 16'h0001);
        alu(3'd2, 8'd3, 8'd1, 8'd2, 1'b0);
        rd(8'd3);
        checks++; if ({flag_zero, flag_carry, flag_ovf} !== 3'b001) begin failures++; $display("FAIL ovf_flags got=%b exp=001", {flag_zero, flag_carry, flag_ovf}); end
        idle(1'b1);
        checks++; if (rdata !== 16'h8000) begin failures++; $display("FAIL ovf_result got=%h exp=8000", rdata); end
        alu(3'd6, 8'd4, 8'd1, 8'd1, 1'b0);
        rd(8'd4);
        checks++; if ({flag_zero, flag_carry, flag_ovf} !== 3'b100) begin failures++; $display("FAIL xor_flags got=%b exp=100", {flag_zero, flag_carry, flag_ovf}); end
        idle(1'b1);
        checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL xor_result got=%h exp=0000", rdata); end
    endtask

    task automatic test_back_to_back_stall();
        wr(8'd20, 16'd100);
        wr(8'd21, 16'd1);
        rd(8'd5);
        idle(1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 3'd2, 8'd20, 8'd21, 8'd20, '0, 1'b0, 1'b0);
            checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL stall_cmd_ready cyc=%0d got=%b exp=0", i, cmd_ready); end
            checks++; if (rd_valid !== 1'b1 || rdata !== 16'h1234) begin failures++; $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/1234", i, rd_valid, rdata); end
        end
        step(1'b0, 1'b1, 3'd2, 8'd20, 8'd21, 8'd20, '0, 1'b0, 1'b1);
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL stall_release got=%b exp=0", rd_valid); end
        rd(8'd20);
        idle(1'b1);
        checks++; if (rdata !== 16'd101) begin failures++; $display("FAIL stall_once got=%0d exp=101", rdata); end
    endtask

    task automatic test_reset_mid();
        wr(8'd31, 16'd0);
        wr(8'd32, 16'd1);
        alu(3'd3, 8'd33, 8'd31, 8'd32, 1'b0);
        wr(8'd7, 16'h5555);
        rd(8'd7);
        wr(8'd7, 16'hAAAA);
        checks++; if (flag_carry !== 1'b1 || rd_valid !== 1'b1) begin failures++; $display("FAIL pre_reset got=%b/%b exp=1/1", flag_carry, rd_valid); end
        step(1'b1, 1'b0, 3'd0, '0, '0, '0, '0, 1'b0, 1'b0);
        checks++; if (rd_valid !== 1'b0 || cmd_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_ctrl got=%b/%b exp=0/0", rd_valid, cmd_ready); end
        checks++; if ({flag_zero, flag_carry, flag_ovf, err} !== 4'b0000) begin failures++; $display("FAIL mid_reset_flags got=%b exp=0000", {flag_zero, flag_carry, flag_ovf, err}); end
        idle(1'b1);
        rd(8'd7);
        idle(1'b1);
        checks++; if (rdata !== 16'h5555) begin failures++; $display("FAIL mid_reset_mem got=%h exp=5555", rdata); end
    endtask

    task automatic test_out_of_range();
        wr(8'd13, 16'h4242);
        alu(3'd2, 8'd12, 8'd10, 8'd11, 1'b0);
        alu(3'd2, 8'd13, 8'd10, 8'd220, 1'b0);
        idle(1'b1);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL oor_alu_err got=%b exp=1", err); end
        checks++; if ({flag_zero, flag_carry} !== 2'b11) begin failures++; $display("FAIL oor_flags_kept got=%b exp=11", {flag_zero, flag_carry}); end
        rd(8'd250);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL oor_err_pulse got=%b exp=0", err); end
        idle(1'b1);
        checks++; if (err !== 1'b1 || rd_valid !== 1'b1 || rdata !== 16'h0000) begin failures++; $display("FAIL oor_read got=%b/%b/%h exp=1/1/0000", err, rd_valid, rdata); end
        rd(8'd13);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL oor_err_clear got=%b exp=0", err); end
        idle(1'b1);
        checks++; if (rdata !== 16'h4242) begin failures++; $display("FAIL oor_no_write got=%h exp=4242", rdata); end
    endtask

    function automatic logic [AW-1:0] pick_addr();
        int r;
        r = $urandom_range(0, 31);
        if (r == 0) return AW'($urandom_range(200, 255));
        if (r < 20) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic test_random();
        logic rst, v, rdy, sat;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 249) == 0);
            v   = ($urandom_range(0, 9) < 8);
            rdy = ($urandom_range(0, 3) != 0);
            sat = 1'($urandom_range(0, 1));
            step(rst, v, 3'($urandom_range(0, 7)), pick_addr(), pick_addr(), pick_addr(),
                 DW'($urandom), sat, rdy);
            checks++; if (cmd_ready !== (!rst && !(e_rd_valid && !rdy))) begin failures++; $display("FAIL rnd_cmd_ready i=%0d got=%b exp=%b", i, cmd_ready, !rst && !(e_rd_valid && !rdy)); end
            checks++; if (rd_valid !== e_rd_valid) begin failures++; $display("FAIL rnd_rd_valid i=%0d got=%b exp=%b", i, rd_valid, e_rd_valid); end
            checks++; if (rdata !== e_rdata) begin failures++; $display("FAIL rnd_rdata i=%0d got=%h exp=%h", i, rdata, e_rdata); end
            checks++; if ({flag_zero, flag_carry, flag_ovf} !== {e_zero, e_carry, e_ovf}) begin failures++; $display("FAIL rnd_flags i=%0d got=%b exp=%b", i, {flag_zero, flag_carry, flag_ovf}, {e_zero, e_carry, e_ovf}); end
            checks++; if (err !== e_err) begin failures++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, err, e_err); end
        end
    endtask

    initial begin
        test_reset();
        fill_memory();
        test_forward();
        test_add_carry();
        test_sub();
        test_ovf_logic();
        test_back_to_back_stall();
        test_reset_mid();
        test_out_of_range();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
